// File: rtl/vending_pkg.sv
// Shared coin/state types and coin values for the change-giving vending machine.
package vending_pkg;

  typedef enum logic [1:0] {COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER} coin_e;
  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_e;

  localparam int NICKEL_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;

  function automatic logic [7:0] coin_cents(coin_e c);
    logic [7:0] v;
    v = 8'd0;
    case (c)
      COIN_NICKEL:  v = 8'(NICKEL_CENTS);
      COIN_DIME:    v = 8'(DIME_CENTS);
      COIN_QUARTER: v = 8'(QUARTER_CENTS);
      default:      v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_classifier.sv
// Synchronises the coin sensor and return button, measures pulse width and
// emits a one-cycle registered coin strobe (COIN_NONE on the strobe = invalid width).
module coin_classifier
  import vending_pkg::*;
#(
  parameter int DIME_MIN    = 2,
  parameter int DIME_MAX    = 4,
  parameter int NICKEL_MIN  = 6,
  parameter int NICKEL_MAX  = 8,
  parameter int QUARTER_MIN = 10,
  parameter int QUARTER_MAX = 12,
  parameter int CNT_W       = 21
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  coin_sensor,
  input  logic  return_req,
  output logic  coin_vld,
  output coin_e coin,
  output logic  ret_sync
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(QUARTER_MAX + 1);

  logic [1:0]       s_sync, r_sync;
  logic             s_d;
  logic [CNT_W-1:0] cnt;
  logic             fall;
  coin_e            cls;

  assign fall     = s_d & ~s_sync[1];
  assign ret_sync = r_sync[1];

  always_comb begin
    cls = COIN_NONE;
    if (cnt >= CNT_W'(DIME_MIN) && cnt <= CNT_W'(DIME_MAX))
      cls = COIN_DIME;
    else if (cnt >= CNT_W'(NICKEL_MIN) && cnt <= CNT_W'(NICKEL_MAX))
      cls = COIN_NICKEL;
    else if (cnt >= CNT_W'(QUARTER_MIN) && cnt <= CNT_W'(QUARTER_MAX))
      cls = COIN_QUARTER;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_sync   <= '0;
      r_sync   <= '0;
      s_d      <= 1'b0;
      cnt      <= '0;
      coin_vld <= 1'b0;
      coin     <= COIN_NONE;
    end else begin
      s_sync   <= {s_sync[0], coin_sensor};
      r_sync   <= {r_sync[0], return_req};
      s_d      <= s_sync[1];
      coin_vld <= fall;
      coin     <= fall ? cls : COIN_NONE;
      // Saturation keeps a stuck sensor from wrapping into a valid range.
      if (!s_sync[1])
        cnt <= '0;
      else if (cnt != SAT)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vending_machine_change.sv
// Credit accumulator and vend/change FSM fed by the coin classifier.
module vending_machine_change
  import vending_pkg::*;
#(
  parameter int DIME_MIN    = 2,
  parameter int DIME_MAX    = 4,
  parameter int NICKEL_MIN  = 6,
  parameter int NICKEL_MAX  = 8,
  parameter int QUARTER_MIN = 10,
  parameter int QUARTER_MAX = 12,
  parameter int PRICE       = 25,
  parameter int MAX_CREDIT  = 95,
  parameter int CREDIT_W    = 8,
  parameter int CNT_W       = 21
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_sensor,
  input  logic                return_req,
  output logic                dispense,
  output logic                nickel_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   NICK_X  = (CREDIT_W+1)'(NICKEL_CENTS);

  logic                coin_vld, ret_sync;
  coin_e               coin;
  state_e              state;
  logic [CREDIT_W:0]   ded, sum;
  logic                coin_ok, rej;
  logic [CREDIT_W-1:0] credit_next;

  coin_classifier #(
    .DIME_MIN(DIME_MIN), .DIME_MAX(DIME_MAX),
    .NICKEL_MIN(NICKEL_MIN), .NICKEL_MAX(NICKEL_MAX),
    .QUARTER_MIN(QUARTER_MIN), .QUARTER_MAX(QUARTER_MAX),
    .CNT_W(CNT_W)
  ) u_cls (
    .clk(clk), .reset_n(reset_n),
    .coin_sensor(coin_sensor), .return_req(return_req),
    .coin_vld(coin_vld), .coin(coin), .ret_sync(ret_sync)
  );

  // Deduction is only taken in states entered with credit >= deduction.
  always_comb begin
    ded = '0;
    case (state)
      S_VEND:   ded = PRICE_X;
      S_CHANGE: ded = NICK_X;
      default:  ded = '0;
    endcase
    sum         = {1'b0, credit} + (CREDIT_W+1)'(coin_cents(coin)) - ded;
    coin_ok     = coin_vld && (coin != COIN_NONE) && (sum <= MAX_X);
    rej         = coin_vld && !coin_ok;
    credit_next = coin_ok ? sum[CREDIT_W-1:0] : (credit - ded[CREDIT_W-1:0]);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      nickel_out  <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      credit      <= credit_next;
      coin_reject <= rej;
      dispense    <= 1'b0;
      nickel_out  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (credit >= CREDIT_W'(PRICE)) begin
            state    <= S_VEND;
            dispense <= 1'b1;
          end else if (ret_sync && credit != '0) begin
            state      <= S_CHANGE;
            nickel_out <= 1'b1;
          end
        end
        S_VEND: state <= S_IDLE;
        S_CHANGE: begin
          // Keep refunding until credit (including any coin just taken) is gone.
          if (credit_next == '0)
            state <= S_IDLE;
          else
            nickel_out <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_change.sv
// Directed bench: default-price machine plus a PRICE=100/MAX_CREDIT=100 instance on shared inputs.
module tb_vending_machine_change;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       coin_sensor = 1'b0;
  logic       return_req = 1'b0;
  logic       dispense, nickel_out, coin_reject, busy;
  logic [7:0] credit;
  logic       dispense_b, nickel_out_b, coin_reject_b, busy_b;
  logic [7:0] credit_b;

  int nerr = 0;
  int nchk = 0;
  int nd = 0, nn = 0, nr = 0;
  int nd_b = 0, nr_b = 0;

  always #5 clk = ~clk;

  vending_machine_change dut (
    .clk(clk), .reset_n(reset_n), .coin_sensor(coin_sensor), .return_req(return_req),
    .dispense(dispense), .nickel_out(nickel_out), .coin_reject(coin_reject),
    .credit(credit), .busy(busy)
  );

  vending_machine_change #(.PRICE(100), .MAX_CREDIT(100)) dut_b (
    .clk(clk), .reset_n(reset_n), .coin_sensor(coin_sensor), .return_req(return_req),
    .dispense(dispense_b), .nickel_out(nickel_out_b), .coin_reject(coin_reject_b),
    .credit(credit_b), .busy(busy_b)
  );

  always @(negedge clk) begin
    if (dispense)      nd++;
    if (nickel_out)    nn++;
    if (coin_reject)   nr++;
    if (dispense_b)    nd_b++;
    if (coin_reject_b) nr_b++;
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Leaves the sensor low just after an edge; the next edge is E0.
  task automatic pulse(input int w);
    coin_sensor = 1'b1;
    repeat (w) @(posedge clk);
    #1 coin_sensor = 1'b0;
  endtask

  task automatic coin(input int w);
    pulse(w);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " credit"}, int'(credit), 0);
    chk({tag, " dispense"}, int'(dispense), 0);
    chk({tag, " nickel_out"}, int'(nickel_out), 0);
    chk({tag, " coin_reject"}, int'(coin_reject), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " credit_b"}, int'(credit_b), 0);
    chk({tag, " outs_b"}, int'({dispense_b, nickel_out_b, coin_reject_b, busy_b}), 0);
  endtask

  typedef struct {
    bit rst;
    bit big;
    int w;
    int credit;
    int disp;
    int rej;
  } vec_t;

  vec_t tv[$];

  initial begin
    int d0, r0, c, first, cnt;
    bit started, ended, gap;

    // Seq/sum tables: {rst, big, width, credit after, dispenses, rejects}
    tv.push_back('{1, 0, 11,  0, 1, 0});
    tv.push_back('{0, 0,  7,  5, 0, 0});
    tv.push_back('{0, 0, 11,  5, 1, 0});
    tv.push_back('{0, 0,  7, 10, 0, 0});
    tv.push_back('{0, 0, 11, 10, 1, 0});
    tv.push_back('{0, 0,  7, 15, 0, 0});
    tv.push_back('{0, 0, 11, 15, 1, 0});
    tv.push_back('{0, 0,  7, 20, 0, 0});
    tv.push_back('{0, 0, 11, 20, 1, 0});
    tv.push_back('{0, 0,  7,  0, 1, 0});
    tv.push_back('{0, 0,  3, 10, 0, 0});
    tv.push_back('{0, 0,  3, 20, 0, 0});
    tv.push_back('{0, 0,  1, 20, 0, 1});
    tv.push_back('{0, 0,  5, 20, 0, 1});
    tv.push_back('{0, 0,  9, 20, 0, 1});
    tv.push_back('{0, 0, 13, 20, 0, 1});
    tv.push_back('{0, 0, 40, 20, 0, 1});
    tv.push_back('{0, 0,  2,  5, 1, 0});
    tv.push_back('{0, 0,  8, 10, 0, 0});
    tv.push_back('{0, 0, 12, 10, 1, 0});
    tv.push_back('{0, 0,  4, 20, 0, 0});
    tv.push_back('{0, 0,  6,  0, 1, 0});
    tv.push_back('{0, 0, 10,  0, 1, 0});
    tv.push_back('{1, 1, 11, 25, 0, 0});
    tv.push_back('{0, 1, 11, 50, 0, 0});
    tv.push_back('{0, 1, 11, 75, 0, 0});
    tv.push_back('{0, 1, 11,  0, 1, 0});
    tv.push_back('{0, 1, 11, 25, 0, 0});
    tv.push_back('{0, 1, 11, 50, 0, 0});
    tv.push_back('{0, 1, 11, 75, 0, 0});
    tv.push_back('{0, 1,  3, 85, 0, 0});
    tv.push_back('{0, 1,  3, 95, 0, 0});
    tv.push_back('{0, 1,  3, 95, 0, 1});
    tv.push_back('{0, 1,  7,  0, 1, 0});

    // Reset state (held in reset from time 0)
    #3;
    chk_zero("reset");
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three dimes with exact vend latency on the third
    coin(3);
    chk("dime1 credit", int'(credit), 10);
    coin(3);
    chk("dime2 credit", int'(credit), 20);
    d0 = nd;
    pulse(3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dime3 credit E3", int'(credit), 30);
    chk("dime3 no dispense E3", int'(dispense), 0);
    @(negedge clk);
    chk("dime3 dispense E4", int'(dispense), 1);
    chk("dime3 busy E4", int'(busy), 1);
    @(negedge clk);
    chk("dime3 dispense low E5", int'(dispense), 0);
    chk("dime3 credit E5", int'(credit), 5);
    repeat (4) @(posedge clk);
    #1 chk("dime3 single vend", nd - d0, 1);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      d0 = tv[i].big ? nd_b : nd;
      r0 = tv[i].big ? nr_b : nr;
      coin(tv[i].w);
      c = tv[i].big ? int'(credit_b) : int'(credit);
      chk($sformatf("vec%0d w%0d credit", i, tv[i].w), c, tv[i].credit);
      chk($sformatf("vec%0d w%0d dispense", i, tv[i].w), (tv[i].big ? nd_b : nd) - d0, tv[i].disp);
      chk($sformatf("vec%0d w%0d reject", i, tv[i].w), (tv[i].big ? nr_b : nr) - r0, tv[i].rej);
    end

    // Change return of 20 cents
    do_reset();
    coin(3);
    coin(3);
    chk("change pre credit", int'(credit), 20);
    return_req = 1'b1;
    @(posedge clk);
    #1 return_req = 1'b0;
    cnt = 0; first = -1; started = 0; ended = 0; gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nickel_out) begin
        if (ended) gap = 1;
        if (!started) first = i;
        started = 1;
        cnt++;
      end else if (started) ended = 1;
    end
    chk("change nickel count", cnt, 4);
    chk("change consecutive", int'(gap), 0);
    chk("change prompt", int'(first >= 0 && first <= 4), 1);
    chk("change credit", int'(credit), 0);
    chk("change busy", int'(busy), 0);

    // Reset mid-quarter; sensor still high after release counts from zero
    coin(3);
    coin(3);
    r0 = nr;
    coin_sensor = 1'b1;
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("rst quarter");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 coin_sensor = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst quarter recount credit", int'(credit), 10);
    chk("rst quarter no reject", nr - r0, 0);

    // Reset mid-change
    coin(3);
    chk("rst change pre credit", int'(credit), 20);
    return_req = 1'b1;
    @(posedge clk);
    #1 return_req = 1'b0;
    cnt = 0;
    while (!nickel_out && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst change nickel seen", int'(nickel_out), 1);
    #1 reset_n = 1'b0;
    #1 chk_zero("rst change");
    d0 = nd;
    c = nn;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rst change no nickel", nn - c, 0);
    chk("rst change no dispense", nd - d0, 0);
    chk("rst change credit", int'(credit), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
